// File: rtl/dac_path_scheduler.sv
// dac_path_scheduler: shares one serial DAC bus (din/clk_out, one active-low
// sync per path) among NUM_PATH transmit paths. Winner word is latched on
// arbitration and shifted MSB-first, one bit per 2*CLK_DIV clk cycles,
// followed by GAP idle cycles with sync high.
// Build option: define DAC_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins
// priority instead of the default round-robin arbitration.
module dac_path_scheduler #(
   parameter int NUM_PATH = 2,
   parameter int DATA_W   = 16,
   parameter int CLK_DIV  = 2,
   parameter int GAP      = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic [NUM_PATH-1:0]           req_i,
   input  logic [NUM_PATH*DATA_W-1:0]    data_i,
   output logic [NUM_PATH-1:0]           ack_o,
   output logic                          din_o,
   output logic                          clk_out_o,
   output logic [NUM_PATH-1:0]           sync_o,
   output logic                          busy_o,
   output logic [$clog2(NUM_PATH)-1:0]   cur_path_o
);

   localparam int PW = $clog2(NUM_PATH);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(2*CLK_DIV) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV-1);
   localparam logic [DW-1:0] BIT_LAST  = DW'(2*CLK_DIV-1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W-1);
   localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP-1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     sr_q, sr_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DW-1:0]         div_q, div_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  clk_out_q, clk_out_d;
   logic [NUM_PATH-1:0]   sync_q, sync_d;
   logic [NUM_PATH-1:0]   ack_q, ack_d;
   logic [PW-1:0]         cur_q, cur_d;

   logic                  any_req;
   logic [PW-1:0]         win;

   assign any_req = |req_i;

`ifdef DAC_SCHED_FIXED_PRIO_EN
   // Fixed priority: lowest-index requesting path wins.
   always_comb begin
      win = '0;
      for (int i = NUM_PATH-1; i >= 0; i--) begin
         if (req_i[i]) win = PW'(i);
      end
   end
`else
   logic [PW-1:0] last_q;
   logic [PW-1:0] win_hi, win_lo;
   logic          win_hi_vld;

   // Round-robin: lowest requester above last wins, else wrap to lowest overall.
   always_comb begin
      win_hi     = '0;
      win_lo     = '0;
      win_hi_vld = 1'b0;
      for (int i = NUM_PATH-1; i >= 0; i--) begin
         if (req_i[i]) win_lo = PW'(i);
         if (req_i[i] && (PW'(i) > last_q)) begin
            win_hi     = PW'(i);
            win_hi_vld = 1'b1;
         end
      end
      win = win_hi_vld ? win_hi : win_lo;
   end

   // Remember the last served path; reset so that path 0 wins first.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i)                        last_q <= PW'(NUM_PATH-1);
      else if (state_q == S_IDLE && any_req) last_q <= win;
   end
`endif

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         sr_q      <= '0;
         bit_q     <= '0;
         div_q     <= '0;
         gap_q     <= '0;
         clk_out_q <= 1'b1;
         sync_q    <= '1;
         ack_q     <= '0;
         cur_q     <= '0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_q     <= bit_d;
         div_q     <= div_d;
         gap_q     <= gap_d;
         clk_out_q <= clk_out_d;
         sync_q    <= sync_d;
         ack_q     <= ack_d;
         cur_q     <= cur_d;
      end
   end

   // Next-state: arbitrate in IDLE, shift bits in SHIFT, count out the gap.
   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_d     = bit_q;
      div_d     = div_q;
      gap_d     = gap_q;
      clk_out_d = clk_out_q;
      sync_d    = sync_q;
      ack_d     = '0;
      cur_d     = cur_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               sr_d      = data_i[int'(win)*DATA_W +: DATA_W];
               ack_d     = NUM_PATH'(1) << win;
               sync_d    = ~(NUM_PATH'(1) << win);
               cur_d     = win;
               bit_d     = '0;
               div_d     = '0;
               clk_out_d = 1'b1;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            div_d = div_q + 1'b1;
            // Mid-bit: falling clk_out edge, where the DAC samples din.
            if (div_q == HALF_LAST) clk_out_d = 1'b0;
            // Bit boundary: rising clk_out, din advances or the frame closes.
            if (div_q == BIT_LAST) begin
               div_d     = '0;
               clk_out_d = 1'b1;
               if (bit_q == LAST_BIT) begin
                  sr_d    = '0;
                  sync_d  = '1;
                  gap_d   = '0;
                  state_d = (GAP == 0) ? S_IDLE : S_GAP;
               end else begin
                  sr_d  = sr_q << 1;
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_d = S_IDLE;
            else                   gap_d   = gap_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ack_o      = ack_q;
   assign din_o      = sr_q[DATA_W-1];
   assign clk_out_o  = clk_out_q;
   assign sync_o     = sync_q;
   assign busy_o     = (state_q != S_IDLE);
   assign cur_path_o = cur_q;

endmodule

// File: doc/dac_path_scheduler.md
# dac_path_scheduler

Round-robin scheduler sharing one serial DAC bus (common `din`/`clk_out`, one active-low `sync` per path) among `NUM_PATH` ultrasound transmit paths. Each path raises a level request with a data word. The block arbitrates between paths, latches the winning word, and shifts it MSB-first as one framed serial write to that path's DAC. It sits between the per-path waveform generators and the board DAC pins, replacing single-path serializer logic in `main`.

## Interface
- `NUM_PATH`, 2, number of requesting paths / DAC chips (2..8)
- `DATA_W`, 16, bits per DAC frame
- `CLK_DIV`, 2, `clk` cycles per `clk_out` half-period (≥1)
- `GAP`, 4, `clk` cycles `sync` held high after each frame (≥0)

- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req`  in  NUM_PATH  level request per path; data must stay stable while high
- `data`  in  NUM_PATH*DATA_W  path i word at `[i*DATA_W +: DATA_W]`
- `ack`  out  NUM_PATH  one-cycle pulse: word of path i latched
- `din`  out  1  serial data, MSB first
- `clk_out`  out  1  serial clock, idles high
- `sync`  out  NUM_PATH  per-DAC frame select, active low
- `busy`  out  1  high in any state other than IDLE
- `cur_path`  out  $clog2(NUM_PATH)  path of current/last frame

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE: if any `req` is high, choose a winner by round-robin, searching from `last+1` and wrapping modulo `NUM_PATH`. On the next edge:
  - load the shift register;
  - pulse `ack[winner]`;
  - drive `sync[winner]` low;
  - set `cur_path` and `last` to the winner;
  - go to SHIFT.
- If no request is high, stay in IDLE.
- SHIFT: each bit lasts `2*CLK_DIV` cycles: `clk_out` high for `CLK_DIV` cycles, then low for `CLK_DIV` cycles.
  - `din` changes only at bit boundaries, on the rising `clk_out` edge. The DAC samples on the falling edge.
  - A bit counter counts 0..DATA_W-1.
  - After the low phase of the last bit: `clk_out` goes high, `sync` goes all-high, `din` goes 0, go to GAP.
- GAP: count `GAP` cycles, then go to IDLE. If `GAP`=0, go directly to IDLE.
- Requests are sampled only in IDLE. A request withdrawn before its ack is simply not served. A request still high after its ack is served again on a later arbitration.
- Simultaneous requests: exactly one winner per IDLE cycle; no path starves.
- At most one `sync` bit is low at any time. `ack` is one-hot or zero.

## Timing
- Reset values: `sync` all 1, `clk_out` 1, `din` 0, `ack` 0, `busy` 0, `cur_path` 0, state IDLE, `last` = NUM_PATH-1 (path 0 wins first).
- Reset asserted mid-frame takes effect on the next edge: `sync` high immediately. The partial frame is discarded and not re-acked.
- Latency: from `req` high in IDLE to `sync` low and `ack` is 1 cycle. `ack` is coincident with the first cycle of `sync` low.
- `sync` stays low for exactly `2*CLK_DIV*DATA_W` cycles.
- `clk_out` has exactly `DATA_W` falling edges per frame, all while `sync` is low.
- Minimum `sync` high time between frames is `GAP+1` cycles (GAP plus one IDLE arbitration cycle).
- Back-to-back frame period = `2*CLK_DIV*DATA_W + GAP + 1` cycles.

## Configuration
- `DAC_SCHED_FIXED_PRIO_EN` defined: fixed priority; the lowest-index requesting path always wins, and the `last` pointer is unused.
- Not defined: round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use defaults (NUM_PATH=2, DATA_W=16, CLK_DIV=2, GAP=4).

- Single path: `req[0]`=1, `data[15:0]`=16'hA55A, held → `ack[0]` pulses 1 cycle later. `sync[0]` is low for 64 cycles and `sync[1]` stays 1. Bits sampled on the 16 `clk_out` falling edges = A55A MSB-first.
- Both requesting continuously, path0=16'h1234, path1=16'hBEEF → frames alternate 0,1,0,1 and `cur_path` alternates. Each `sync` low period is 64 cycles; `sync` high gap is 5 cycles; frame period is 69.
- `DAC_SCHED_FIXED_PRIO_EN` with both requesting → only path 0 is served while `req[0]` stays high. Path 1 is served in the first frame after `req[0]` drops.
- Reset mid-frame: `rst_n`=0 at cycle 20 of the SHIFT state → next edge gives all `sync` 1, `clk_out` 1, `din` 0, `busy` 0. After release, path 0 wins first.
- Request pulse during SHIFT: `req[1]` high for 10 cycles inside a path-0 frame → no `ack[1]` and no path-1 frame.
- Invariant checks throughout: never more than one `sync` low; no `clk_out` edge while all `sync` are high; `ack` is never multi-hot.
